// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Recovers the hex value shown on each position of a multiplexed 7-segment
//   display bus. Samples seg/an, waits for a pattern to remain stable for
//   STABLE_CYC consecutive samples, then decodes it back to a 4-bit digit.
//
//   Build option SEG_ACTIVE_LOW_EN: when defined, seg and an are inverted
//   before the input register (common-anode boards). Decoding and timing then
//   apply to the inverted values.
//
//   Parameters:
//     NDIG        number of digit positions (1..8)
//     STABLE_CYC  identical consecutive samples required before capture (2..255)

module seven_seg_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg,
  input  logic [NDIG-1:0]     an,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     valid,
  output logic                frame_done,
  output logic                bad_pat
);

  // Run-length target as a counter-width constant.
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYC);

  // Segment pattern to {hit, value}; hit=0 means the pattern is not a glyph.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h7E:   res = 5'h10;
      7'h30:   res = 5'h11;
      7'h6D:   res = 5'h12;
      7'h79:   res = 5'h13;
      7'h33:   res = 5'h14;
      7'h5B:   res = 5'h15;
      7'h5F:   res = 5'h16;
      7'h70:   res = 5'h17;
      7'h7F:   res = 5'h18;
      7'h7B:   res = 5'h19;
      7'h77:   res = 5'h1A;
      7'h1F:   res = 5'h1B;
      7'h4E:   res = 5'h1C;
      7'h3D:   res = 5'h1D;
      7'h4F:   res = 5'h1E;
      7'h47:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  // True when exactly one bit of the digit-enable vector is set.
  function automatic logic is_one_hot(input logic [NDIG-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < NDIG; i++) begin
      ones = ones + int'(v[i]);
    end
    return (ones == 1);
  endfunction

  // Polarity-corrected inputs
  logic [6:0]      seg_in_s;
  logic [NDIG-1:0] an_in_s;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in_s = ~seg;
  assign an_in_s  = ~an;
`else
  assign seg_in_s = seg;
  assign an_in_s  = an;
`endif

  // Input stage registers
  logic [6:0]      seg_r;
  logic [NDIG-1:0] an_r;
  logic [7:0]      cnt_r;
  logic            fire_r;
  logic [7:0]      cnt_next_s;
  logic            fire_next_s;

  // Capture stage registers
  logic [4*NDIG-1:0] digits_r;
  logic [NDIG-1:0]   valid_r;
  logic [NDIG-1:0]   mask_r;
  logic              frame_done_r;
  logic              bad_pat_r;

  logic [4*NDIG-1:0] digits_next_s;
  logic [NDIG-1:0]   valid_next_s;
  logic [NDIG-1:0]   mask_next_s;
  logic [NDIG-1:0]   mask_or_s;
  logic              frame_done_next_s;
  logic              bad_pat_next_s;
  logic [4:0]        glyph_s;

  // Run counter: counts consecutive identical samples, held at 0 while blanked,
  // and flags the single sample on which the run first reaches the target.
  always_comb begin
    cnt_next_s  = 8'd0;
    fire_next_s = 1'b0;
    if (!is_one_hot(an_in_s)) begin
      cnt_next_s = 8'd0;
    end else if ((seg_in_s == seg_r) && (an_in_s == an_r)) begin
      if (cnt_r == STABLE_C) begin
        cnt_next_s = STABLE_C;
      end else begin
        cnt_next_s = cnt_r + 8'd1;
      end
    end else begin
      cnt_next_s = 8'd1;
    end
    fire_next_s = (cnt_next_s == STABLE_C) && (cnt_r != STABLE_C);
  end

  // Input sample register, run counter and capture strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r  <= 7'd0;
      an_r   <= '0;
      cnt_r  <= 8'd0;
      fire_r <= 1'b0;
    end else begin
      seg_r  <= seg_in_s;
      an_r   <= an_in_s;
      cnt_r  <= cnt_next_s;
      fire_r <= fire_next_s;
    end
  end

  assign glyph_s   = decode_glyph(seg_r);
  assign mask_or_s = mask_r | an_r;

  // Capture decision: write the selected digit on a glyph hit, flag a miss,
  // and close the frame once every position has been seen.
  always_comb begin
    digits_next_s     = digits_r;
    valid_next_s      = valid_r;
    mask_next_s       = mask_r;
    frame_done_next_s = 1'b0;
    bad_pat_next_s    = 1'b0;
    if (fire_r) begin
      if (glyph_s[4]) begin
        for (int i = 0; i < NDIG; i++) begin
          digits_next_s[4*i +: 4] = an_r[i] ? glyph_s[3:0] : digits_r[4*i +: 4];
        end
        valid_next_s = valid_r | an_r;
        if (&mask_or_s) begin
          frame_done_next_s = 1'b1;
          mask_next_s       = '0;
        end else begin
          mask_next_s       = mask_or_s;
        end
      end else begin
        bad_pat_next_s = 1'b1;
      end
    end else begin
      mask_next_s = mask_r;
    end
  end

  // Registered digit store, valid flags, frame mask and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_r     <= '0;
      valid_r      <= '0;
      mask_r       <= '0;
      frame_done_r <= 1'b0;
      bad_pat_r    <= 1'b0;
    end else begin
      digits_r     <= digits_next_s;
      valid_r      <= valid_next_s;
      mask_r       <= mask_next_s;
      frame_done_r <= frame_done_next_s;
      bad_pat_r    <= bad_pat_next_s;
    end
  end

  assign digits     = digits_r;
  assign valid      = valid_r;
  assign frame_done = frame_done_r;
  assign bad_pat    = bad_pat_r;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture (NDIG=4, STABLE_CYC=4).
// Directed scenarios followed by random dwells, compared every cycle against
// a behavioural model of the capture rules.

module tb_seven_seg_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [6:0]        seg = 7'd0;
  logic [NDIG-1:0]   an  = '0;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   valid;
  logic              frame_done;
  logic              bad_pat;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int bp_cnt   = 0;

  // Logical (active-high) view of what is currently driven
  logic [6:0]      cur_seg = 7'd0;
  logic [NDIG-1:0] cur_an  = '0;

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state
  int              m_dig [NDIG];
  logic [NDIG-1:0] m_valid;
  logic [NDIG-1:0] m_mask;
  logic            m_fd;
  logic            m_bp;
  logic [6:0]      m_last_seg;
  logic [NDIG-1:0] m_last_an;
  int              m_run;
  logic            m_pend;
  logic [6:0]      m_pend_seg;
  logic [NDIG-1:0] m_pend_an;

  seven_seg_capture #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .an         (an),
    .digits     (digits),
    .valid      (valid),
    .frame_done (frame_done),
    .bad_pat    (bad_pat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [NDIG-1:0] a);
    cur_seg = s;
    cur_an  = a;
`ifdef SEG_ACTIVE_LOW_EN
    seg = ~s;
    an  = ~a;
`else
    seg = s;
    an  = a;
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) m_dig[i] = 0;
    m_valid    = '0;
    m_mask     = '0;
    m_fd       = 1'b0;
    m_bp       = 1'b0;
    m_last_seg = 7'd0;
    m_last_an  = '0;
    m_run      = 0;
    m_pend     = 1'b0;
    m_pend_seg = 7'd0;
    m_pend_an  = '0;
  endtask

  // One clock edge of the reference: first apply a capture decided on the
  // previous edge, then extend or restart the dwell with the sample now taken.
  task automatic model_edge(input logic [6:0] s, input logic [NDIG-1:0] a);
    int new_run;
    int val;
    m_fd = 1'b0;
    m_bp = 1'b0;
    if (m_pend) begin
      val = -1;
      for (int g = 0; g < 16; g++) begin
        if (glyph_tab[g] == m_pend_seg) val = g;
      end
      if (val < 0) begin
        m_bp = 1'b1;
      end else begin
        for (int i = 0; i < NDIG; i++) begin
          if (m_pend_an[i]) m_dig[i] = val;
        end
        m_valid = m_valid | m_pend_an;
        m_mask  = m_mask | m_pend_an;
        if (m_mask == {NDIG{1'b1}}) begin
          m_fd   = 1'b1;
          m_mask = '0;
        end
      end
    end
    m_pend = 1'b0;
    if ($countones(a) != 1) new_run = 0;
    else if (s == m_last_seg && a == m_last_an) new_run = (m_run >= STABLE) ? STABLE : m_run + 1;
    else new_run = 1;
    if (new_run == STABLE && m_run != STABLE) begin
      m_pend     = 1'b1;
      m_pend_seg = s;
      m_pend_an  = a;
    end
    m_last_seg = s;
    m_last_an  = a;
    m_run      = new_run;
  endtask

  task automatic check_all(input string tag);
    logic [4*NDIG-1:0] e;
    for (int i = 0; i < NDIG; i++) e[4*i +: 4] = 4'(m_dig[i]);
    chk({tag, "_digits"}, 32'(digits), 32'(e));
    chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(m_fd));
    chk({tag, "_bad_pat"}, 32'(bad_pat), 32'(m_bp));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(cur_seg, cur_an);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
    if (bad_pat === 1'b1) bp_cnt++;
    check_all(tag);
  endtask

  initial begin
    int fd0;
    int bp0;
    int dwell;
    logic [6:0]      rs;
    logic [NDIG-1:0] ra;
    logic [6:0]      t2_seg [4];
    logic [NDIG-1:0] t2_an  [4];

    t2_seg = '{7'h30, 7'h79, 7'h33, 7'h47};
    t2_an  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    drive(7'h00, 4'b0000);
    model_reset();
    rst = 1'b1;
    #12;
    check_all("reset");
    rst = 1'b0;

    // 1: single stable digit, no re-capture on long dwell
    drive(7'h6D, 4'b0001);
    repeat (4) tick("t1");
    chk("t1_not_yet", 32'(valid), 32'h0);
    tick("t1");
    chk("t1_digit0", 32'(digits[3:0]), 32'h2);
    chk("t1_valid", 32'(valid), 32'h1);
    tick("t1");
    chk("t1_bad_cnt", 32'(bp_cnt), 32'h0);

    // 2: full scan, one frame pulse
    fd0 = fd_cnt;
    for (int k = 0; k < 4; k++) begin
      drive(t2_seg[k], t2_an[k]);
      repeat (8) tick("t2");
    end
    chk("t2_digits", 32'(digits), 32'hF431);
    chk("t2_valid", 32'(valid), 32'hF);
    chk("t2_frame_pulses", 32'(fd_cnt - fd0), 32'h1);

    // 3: short dwell on 0 is discarded, the following full dwell captures
    drive(7'h7E, 4'b0001);
    repeat (3) tick("t3");
    drive(7'h30, 4'b0001);
    repeat (4) tick("t3");
    chk("t3_digit0", 32'(digits[3:0]), 32'h1);
    tick("t3");
    chk("t3_digit0_after", 32'(digits[3:0]), 32'h1);

    // 4: unknown pattern
    bp0 = bp_cnt;
    drive(7'h01, 4'b0010);
    repeat (5) tick("t4");
    chk("t4_bad_pulses", 32'(bp_cnt - bp0), 32'h1);
    chk("t4_valid1", 32'(valid[1]), 32'h1);
    chk("t4_digit1", 32'(digits[7:4]), 32'h3);

    // 5: blanked / multi-select enables, then reset mid-dwell
    bp0 = bp_cnt;
    fd0 = fd_cnt;
    drive(7'h7F, 4'b0011);
    repeat (5) tick("t5");
    drive(7'h7F, 4'b0000);
    repeat (5) tick("t5");
    chk("t5_bad_pulses", 32'(bp_cnt - bp0), 32'h0);
    chk("t5_frame_pulses", 32'(fd_cnt - fd0), 32'h0);
    chk("t5_digits_kept", 32'(digits), 32'hF431);
    drive(7'h4F, 4'b0100);
    repeat (2) tick("t5");
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_digits", 32'(digits), 32'h0);
    chk("t5_rst_valid", 32'(valid), 32'h0);
    chk("t5_rst_pulses", 32'({frame_done, bad_pat}), 32'h0);
    tick("t5_rst");
    rst = 1'b0;
    repeat (4) tick("t5_post");
    chk("t5_post_not_yet", 32'(valid), 32'h0);
    tick("t5_post");
    chk("t5_post_digit2", 32'(digits[11:8]), 32'hE);
    chk("t5_post_valid", 32'(valid), 32'h4);

    // Random dwells against the model
    repeat (80) begin
      dwell = $urandom_range(1, 7);
      if ($urandom_range(0, 4) != 0) rs = glyph_tab[$urandom_range(0, 15)];
      else rs = 7'($urandom);
      if ($urandom_range(0, 4) != 0) ra = 4'(1 << $urandom_range(0, NDIG - 1));
      else ra = 4'($urandom);
      drive(rs, ra);
      repeat (dwell) tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
